// File: rtl/uart_receiver_core_pkg.sv
// Shared constants for the oversampling UART receiver: FSM encodings and
// sample-point positions within a 16x oversampled bit.
package uart_receiver_core_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_DATA      = 3'd2;
    localparam state_t ST_STOP      = 3'd3;
    localparam state_t ST_WAIT_HIGH = 3'd4;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_receiver_core_if.sv
// Receiver-side bundle: serial input plus the parallel word, its strobes and status.
// valid/frame_error are single-cycle strobes with no back-pressure; dout is held until the next good word.
interface uart_receiver_core_if #(
    parameter int N = 8
) ();
    import uart_receiver_core_pkg::*;

    logic         rx;
    logic [N-1:0] dout;
    logic         valid;
    logic         frame_error;
    logic         busy;
    state_t       state;

    modport master (
        input  rx,
        output dout, valid, frame_error, busy, state
    );

    modport slave (
        output rx,
        input  dout, valid, frame_error, busy, state
    );

endinterface

// File: rtl/uart_receiver_core_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every CLK_DIV clocks.
module uart_baud_tick_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(CLK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_receiver_core.sv
// 16x oversampling UART receiver: synchroniser, frame FSM, shift register and
// registered output strobes. Bad stop bits park in WAIT_HIGH until the line recovers.
module uart_receiver_core
    import uart_receiver_core_pkg::*;
#(
    parameter int N                   = 8,
    parameter int NUMBER_OF_STOP_BITS = 1,
    parameter int CLK_DIV             = 27
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_receiver_core_if.master bus
);
    localparam int BW = $clog2(N + 1);

    logic          tick;
    logic          rx_meta_q, rxs_q;
    state_t        state_q, state_d;
    logic [3:0]    s_cnt_q, s_cnt_d;
    logic [BW-1:0] b_cnt_q, b_cnt_d;
    logic [N-1:0]  sh_q, sh_d;
    logic          err_q, err_d, err_samp;
    logic [N-1:0]  dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    uart_baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        s_cnt_d  = s_cnt_q;
        b_cnt_d  = b_cnt_q;
        sh_d     = sh_q;
        err_d    = err_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        err_samp = err_q | ~rxs_q;

        case (state_q)
            ST_IDLE: begin
                // Edge detection runs every clock so start-bit phase error stays under one tick.
                if (!rxs_q) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_cnt_q == MID_SAMPLE) begin
                        if (!rxs_q) begin
                            state_d = ST_DATA;
                            s_cnt_d = '0;
                            b_cnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_cnt_q == LAST_SAMPLE) begin
                        sh_d    = {rxs_q, sh_q[N-1:1]};
                        s_cnt_d = '0;
                        if (b_cnt_q == BW'(N - 1)) begin
                            state_d = ST_STOP;
                            b_cnt_d = '0;
                            err_d   = 1'b0;
                        end else begin
                            b_cnt_d = b_cnt_q + BW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_cnt_q == LAST_SAMPLE) begin
                        s_cnt_d = '0;
                        if (b_cnt_q == BW'(NUMBER_OF_STOP_BITS - 1)) begin
                            b_cnt_d = '0;
                            if (err_samp) begin
                                ferr_d  = 1'b1;
                                state_d = ST_WAIT_HIGH;
                            end else begin
                                dout_d  = sh_q;
                                valid_d = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end else begin
                            err_d   = err_samp;
                            b_cnt_d = b_cnt_q + BW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= ST_IDLE;
            s_cnt_q   <= '0;
            b_cnt_q   <= '0;
            sh_q      <= '0;
            err_q     <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= bus.rx;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            b_cnt_q   <= b_cnt_d;
            sh_q      <= sh_d;
            err_q     <= err_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.valid       = valid_q;
    assign bus.frame_error = ferr_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.state       = state_q;

endmodule
